// File: rtl/bf_pkg.sv
// Shared brainfuck definitions: command byte encodings, loader states and
// the command-character classifier used by the loader and fetch side.
package bf_pkg;

    localparam logic [7:0] CMD_INC   = 8'h2B;
    localparam logic [7:0] CMD_DEC   = 8'h2D;
    localparam logic [7:0] CMD_LEFT  = 8'h3C;
    localparam logic [7:0] CMD_RIGHT = 8'h3E;
    localparam logic [7:0] CMD_OUT   = 8'h2E;
    localparam logic [7:0] CMD_IN    = 8'h2C;
    localparam logic [7:0] CMD_LOOP  = 8'h5B;
    localparam logic [7:0] CMD_END   = 8'h5D;
    localparam logic [7:0] CMD_HALT  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TERM,
        ST_DONE
    } load_state_e;

    function automatic logic is_command(input logic [7:0] b);
        case (b)
            CMD_INC, CMD_DEC, CMD_LEFT, CMD_RIGHT,
            CMD_OUT, CMD_IN, CMD_LOOP, CMD_END: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bf_program_loader_if.sv
// Host-stream, program-RAM write and status signals of the program loader.
// master = host/bench side, slave = loader.
interface bf_program_loader_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  busy;
    logic                  done;
    logic                  err_overflow;
    logic                  err_unbalanced;
    logic [ADDR_WIDTH:0]   prog_len;

    modport master (
        output start, in_data, in_valid, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done,
               err_overflow, err_unbalanced, prog_len
    );

    modport slave (
        input  start, in_data, in_valid, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done,
               err_overflow, err_unbalanced, prog_len
    );
endinterface

// File: rtl/bf_bracket_tracker.sv
// Bracket nesting counter with a sticky unbalanced flag; reusable by any
// block that walks a command stream in order.
module bf_bracket_tracker #(
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   check_zero,
    output logic [DEPTH_WIDTH-1:0] depth,
    output logic                   unbalanced
);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth      <= '0;
            unbalanced <= 1'b0;
        end else if (clear) begin
            depth      <= '0;
            unbalanced <= 1'b0;
        end else begin
            // Overflowing or underflowing depth leaves it pinned and flags the error.
            if (push) begin
                if (depth == DEPTH_MAX) unbalanced <= 1'b1;
                else                    depth      <= depth + 1'b1;
            end else if (pop) begin
                if (depth == '0) unbalanced <= 1'b1;
                else             depth      <= depth - 1'b1;
            end
            if (check_zero && depth != '0) unbalanced <= 1'b1;
        end
    end
endmodule

// File: rtl/bf_program_loader.sv
// Filters a host byte stream down to brainfuck commands, writes them into
// program RAM with a trailing 0x00 terminator, and reports length/errors.
module bf_program_loader
    import bf_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bf_program_loader_if.slave   bus
);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    load_state_e           state, state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  in_ready;
    logic                  accept, cmd, full, write_cmd, load_start;
    logic                  err_overflow;
    logic [ADDR_WIDTH:0]   prog_len;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic [DEPTH_WIDTH-1:0] depth;
    logic                  unbalanced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start) state_next = ST_LOAD;
            ST_LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) state_next = ST_TERM;
            end
            ST_TERM: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept     = bus.in_valid && in_ready;
    assign cmd        = is_command(bus.in_data);
    // The last slot is kept free for the terminator.
    assign full       = (ptr == PTR_LAST);
    assign write_cmd  = accept && cmd && !full;
    assign load_start = bus.start && (state == ST_IDLE || state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            err_overflow <= 1'b0;
            prog_len     <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            mem_we <= write_cmd || (state == ST_TERM);
            if (load_start) begin
                ptr          <= '0;
                err_overflow <= 1'b0;
                prog_len     <= '0;
            end
            if (write_cmd) begin
                mem_addr  <= ptr;
                mem_wdata <= bus.in_data;
                ptr       <= ptr + 1'b1;
            end
            if (accept && cmd && full) err_overflow <= 1'b1;
            if (state == ST_TERM) begin
                mem_addr  <= ptr;
                mem_wdata <= CMD_HALT;
                prog_len  <= {1'b0, ptr};
            end
        end
    end

    bf_bracket_tracker #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_brackets (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load_start),
        .push       (write_cmd && bus.in_data == CMD_LOOP),
        .pop        (write_cmd && bus.in_data == CMD_END),
        .check_zero (state == ST_TERM),
        .depth      (depth),
        .unbalanced (unbalanced)
    );

    assign bus.in_ready       = in_ready;
    assign bus.mem_we         = mem_we;
    assign bus.mem_addr       = mem_addr;
    assign bus.mem_wdata      = mem_wdata;
    assign bus.busy           = (state == ST_LOAD) || (state == ST_TERM);
    assign bus.done           = (state == ST_DONE);
    assign bus.err_overflow   = err_overflow;
    assign bus.err_unbalanced = unbalanced;
    assign bus.prog_len       = prog_len;
endmodule

// File: tb/tb_bf_program_loader.sv
// Randomized self-checking bench for bf_program_loader against a queue-based
// model of the filtered program image, length and error flags.
module tb_bf_program_loader;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int SLOTS = (1 << AW) - 1;

    typedef byte unsigned bq_t[$];
    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bf_program_loader_if #(.ADDR_WIDTH(AW)) bus();

    bf_program_loader #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    wr_t wr_q[$];
    bit  lat_en = 1'b0;
    int  lat_n = 0, lat_bad = 0, ready_bad = 0;
    bit  pend = 1'b0;

    function automatic bit tb_is_cmd(input logic [7:0] b);
        return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D};
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Bus monitor: captures RAM writes and tracks write-after-accept timing.
    always @(negedge clk) begin
        if (bus.mem_we) wr_q.push_back('{bus.mem_addr, bus.mem_wdata});
        if (!bus.busy && bus.in_ready) ready_bad++;
        if (lat_en) begin
            lat_n++;
            if (bus.mem_we !== pend) lat_bad++;
        end
        pend = (bus.in_valid && bus.in_ready && tb_is_cmd(bus.in_data)) ||
               (bus.busy && !bus.in_ready);
    end

    // Reference: expected RAM image (index = address), length and flags.
    task automatic model(input bq_t s, output bq_t img, output int plen,
                         output bit ovf, output bit unb);
        bq_t cmds;
        int d = 0;
        img = {}; ovf = 0; unb = 0;
        foreach (s[i]) if (tb_is_cmd(s[i])) cmds.push_back(s[i]);
        foreach (cmds[i]) begin
            if (img.size() == SLOTS) begin ovf = 1; continue; end
            img.push_back(cmds[i]);
            if (cmds[i] == 8'h5B) begin
                if (d == (1 << DW) - 1) unb = 1; else d++;
            end else if (cmds[i] == 8'h5D) begin
                if (d == 0) unb = 1; else d--;
            end
        end
        if (d != 0) unb = 1;
        plen = img.size();
        img.push_back(8'h00);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_stream(input string name, input bq_t s, input bit last_on, input bit gaps);
        int i = 0, cyc = 0;
        bit acc;
        while (i < s.size() && cyc < 500) begin
            bus.in_data  = s[i];
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_last  = last_on && (i == s.size() - 1);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checks++;
        if (i != s.size()) begin
            failures++;
            $display("FAIL %s stream_accept: accepted %0d bytes, required %0d", name, i, s.size());
        end
    endtask

    task automatic run_load(input string name, input bq_t s, input bit gaps);
        bq_t img;
        int plen, base, c;
        bit ovf, unb;
        base = wr_q.size();
        do_start();
        send_stream(name, s, 1'b1, gaps);
        c = 0;
        do begin @(negedge clk); c++; end while (!bus.done && c < 50);
        @(posedge clk); #1;
        model(s, img, plen, ovf, unb);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++; $display("FAIL %s done: got %b, required 1", name, bus.done);
        end
        checks++;
        if (wr_q.size() - base != img.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wr_q.size() - base, img.size());
        end else begin
            foreach (img[i]) begin
                checks++;
                if (wr_q[base+i].addr !== AW'(i) || wr_q[base+i].data !== img[i]) begin
                    failures++;
                    $display("FAIL %s write[%0d]: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             name, i, wr_q[base+i].addr, wr_q[base+i].data, i, img[i]);
                end
            end
        end
        checks++;
        if (bus.prog_len !== (AW+1)'(plen)) begin
            failures++; $display("FAIL %s prog_len: got %0d, required %0d", name, bus.prog_len, plen);
        end
        checks++;
        if (bus.err_overflow !== ovf) begin
            failures++; $display("FAIL %s err_overflow: got %b, required %b", name, bus.err_overflow, ovf);
        end
        checks++;
        if (bus.err_unbalanced !== unb) begin
            failures++; $display("FAIL %s err_unbalanced: got %b, required %b", name, bus.err_unbalanced, unb);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL %s done_idle: got busy=%b in_ready=%b mem_we=%b, required 0 0 0",
                     name, bus.busy, bus.in_ready, bus.mem_we);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.err_overflow, bus.err_unbalanced} !== 6'b0) begin
            failures++;
            $display("FAIL %s flags: got rdy=%b we=%b busy=%b done=%b ovf=%b unb=%b, required all 0", name,
                     bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.err_overflow, bus.err_unbalanced);
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== 8'h00 || bus.prog_len !== '0) begin
            failures++;
            $display("FAIL %s data: got addr=%0h wdata=%0h len=%0d, required 0 0 0",
                     name, bus.mem_addr, bus.mem_wdata, bus.prog_len);
        end
    endtask

    function automatic bq_t rand_stream(input int len);
        string pool = "+-<>.,[]a \nZ";
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
        return q;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("post_reset_idle");
    endtask

    task automatic test_basic();
        run_load("basic", str2q("+[.+]>-[.-]"), 1'b0);
    endtask

    task automatic test_filter();
        run_load("filter", str2q("+ a[\n.]x"), 1'b0);
        run_load("empty", str2q("q"), 1'b0);
    endtask

    task automatic test_backpressure();
        lat_en = 1'b1;
        for (int k = 0; k < 4; k++) run_load("backpressure", rand_stream($urandom_range(1, 12)), 1'b1);
        lat_en = 1'b0;
        checks++;
        if (lat_n == 0 || lat_bad != 0) begin
            failures++; $display("FAIL write_latency: got %0d bad of %0d cycles, required 0 bad", lat_bad, lat_n);
        end
        checks++;
        if (ready_bad != 0) begin
            failures++; $display("FAIL ready_outside_load: got %0d cycles, required 0", ready_bad);
        end
    endtask

    task automatic test_overflow();
        bq_t s;
        for (int i = 0; i < 17; i++) s.push_back(8'h2B);
        run_load("overflow", s, 1'b0);
    endtask

    task automatic test_brackets();
        run_load("close_first", str2q("]+"), 1'b0);
        run_load("open_unclosed", str2q("[[+"), 1'b0);
        run_load("balanced", str2q("[]"), 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) run_load("random", rand_stream($urandom_range(1, 25)), 1'b1);
    endtask

    task automatic test_reset_midload();
        do_start();
        send_stream("midload", str2q("+->"), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midload_reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_load("after_reset", str2q("<>"), 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        test_reset();
        test_basic();
        test_filter();
        test_backpressure();
        test_overflow();
        test_brackets();
        test_random();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bf_program_loader.md
Name: bf_program_loader

Overview:
Writer side of the brainfuck program memory: receives a byte stream (host/UART side) and writes it into program RAM, which the processor fetch unit later reads. Keeps only the eight brainfuck command characters and drops everything else. Appends the 0x00 end-of-program terminator that fetch relies on. Tracks bracket balance and capacity, and reports program length and error status.

Parameters:
ADDR_WIDTH, 4, program memory address width; depth = 2^ADDR_WIDTH bytes, last slot reserved for terminator
DEPTH_WIDTH, 4, width of bracket nesting counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a load; ignored while busy
in_data  in  8  stream byte
in_valid  in  1  stream byte valid
in_last  in  1  marks final stream byte, qualified by in_valid
in_ready  out  1  loader accepts byte this cycle
mem_we  out  1  program RAM write enable
mem_addr  out  ADDR_WIDTH  program RAM write address
mem_wdata  out  8  program RAM write data
busy  out  1  high in LOAD and TERM
done  out  1  high in DONE until next start
err_overflow  out  1  command dropped for lack of space (sticky per load)
err_unbalanced  out  1  bracket mismatch (sticky per load)
prog_len  out  ADDR_WIDTH+1  commands written, excluding terminator; valid when done

Behaviour:
- Reset: state IDLE; all outputs 0; write pointer 0; depth 0.
- States: IDLE, LOAD, TERM, DONE.
- IDLE/DONE + start -> LOAD. Clear pointer, depth, both error flags and done.
- LOAD: in_ready=1. A byte is accepted when in_valid && in_ready.
- Command set: 0x2B + , 0x2D - , 0x3C < , 0x3E > , 0x2E . , 0x2C , , 0x5B [ , 0x5D ]. Other bytes are accepted and discarded.
- Accepted command with pointer < 2^ADDR_WIDTH-1:
  - Registered write: mem_we=1, mem_addr=pointer, mem_wdata=byte on the cycle after acceptance (1-cycle latency).
  - Then pointer++.
- Accepted command with pointer == 2^ADDR_WIDTH-1: no write; err_overflow set; loading continues, draining the stream until in_last.
- Bracket tracking (only for commands that are written):
  - '[' increments depth. If depth is at its maximum, depth saturates and err_unbalanced is set.
  - ']' at depth 0 sets err_unbalanced and leaves depth at 0. Otherwise depth is decremented.
- in_last accepted (whether or not it is a command) -> TERM after that byte is processed.
- TERM: in_ready=0. Issue a write of 0x00 at the pointer (mem_we the next cycle). Set prog_len=pointer. If depth != 0, set err_unbalanced. -> DONE.
- DONE: done=1, in_ready=0, mem_we=0. Error flags and prog_len hold.
- mem_we is a single-cycle pulse per write. There is exactly one write per command written, plus one terminator write.
- start asserted in LOAD/TERM is ignored.
- rst_n low at any point (mid-load included) immediately returns to the reset state. Partial RAM contents are left as-is, and no terminator is written.
- Empty stream (first accepted byte has in_last and is a non-command): terminator is written at address 0, prog_len=0.

Decomposition:
- Shared package bf_pkg holds:
  - Command byte constants (CMD_INC 0x2B, CMD_DEC 0x2D, CMD_LEFT 0x3C, CMD_RIGHT 0x3E, CMD_OUT 0x2E, CMD_IN 0x2C, CMD_LOOP 0x5B, CMD_END 0x5D, CMD_HALT 0x00).
  - The loader state enum.
  - An is_command function.
- One natural sub-module: bf_bracket_tracker (depth counter + unbalanced flag), which the fetch unit can reuse.

Test Plan:
- Stream "+[.+]>-[.-]" (11 bytes, last on ']'):
  - Writes at 0x0..0xA match the input.
  - 0x00 is written at 0xB.
  - prog_len=11, no errors, done=1.
- Stream "+ a[\n.]x" with last on 'x':
  - Only "+[.]" is written at 0..3, terminator at 4.
  - prog_len=4, no errors.
- Backpressure: in_valid toggled randomly and in_ready checked low outside LOAD. Each accepted command is followed by mem_we exactly 1 cycle later; no write occurs without a prior acceptance.
- Stream of 17 '+' (ADDR_WIDTH=4):
  - 15 writes at 0..0xE, terminator at 0xF.
  - prog_len=15, err_overflow=1.
- Bracket errors:
  - "]+" gives err_unbalanced=1.
  - "[[+" gives err_unbalanced=1 set in TERM.
  - A subsequent start plus "[]" clears the flags and gives prog_len=2.
- rst_n pulsed low after 3 accepted commands: all outputs are 0 asynchronously and state is IDLE. The next start and a 2-byte load give prog_len=2.
